zhilo_capture: RTL

Result-capture stage directly downstream of the 64-bit ALU output C. It latches C into the 64-bit Z register on the Zin strobe and drives ZLo or ZHi back onto the 32-bit datapath bus. For multiply and divide results, it sequences a two-cycle write-back into the LO and HI registers, LO first, under a small FSM. It also reports busy and done status to the control unit.

---
 rtl/zhilo_capture_pkg.sv | 31 +++
 rtl/zhilo_bus_mux.sv | 21 ++
 rtl/zhilo_capture.sv | 86 ++++++++
 3 files changed

// File: rtl/zhilo_capture_pkg.sv
// Shared constants for the Z capture / HI-LO write-back stage:
// ALU opcode map, FSM state encoding and the default datapath width.
package zhilo_capture_pkg;

    localparam int WORD_SIZE = 32;

    // ALU opcodes (5-bit)
    localparam logic [4:0] OPC_NOP  = 5'b00000;
    localparam logic [4:0] OPC_ADD  = 5'b00001;
    localparam logic [4:0] OPC_SUB  = 5'b00010;
    localparam logic [4:0] OPC_MUL  = 5'b00011;
    localparam logic [4:0] OPC_DIV  = 5'b00100;
    localparam logic [4:0] OPC_SHR  = 5'b00101;
    localparam logic [4:0] OPC_SHL  = 5'b00110;
    localparam logic [4:0] OPC_SHRA = 5'b00111;
    localparam logic [4:0] OPC_ROR  = 5'b01000;
    localparam logic [4:0] OPC_ROL  = 5'b01001;
    localparam logic [4:0] OPC_AND  = 5'b01010;
    localparam logic [4:0] OPC_OR   = 5'b01011;
    localparam logic [4:0] OPC_NEG  = 5'b01100;
    localparam logic [4:0] OPC_XOR  = 5'b01101;
    localparam logic [4:0] OPC_NOR  = 5'b01110;
    localparam logic [4:0] OPC_NOT  = 5'b01111;

    // Capture / write-back FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_CAP   = 2'b01;
    localparam logic [1:0] ST_WB_LO = 2'b10;
    localparam logic [1:0] ST_WB_HI = 2'b11;

endpackage

// File: rtl/zhilo_bus_mux.sv
// ZLo/ZHi priority mux onto the datapath bus. Low word wins when both
// selects are asserted; nothing selected drives zero.
module zhilo_bus_mux #(
    parameter int WORD = 32
) (
    input  logic [2*WORD-1:0] z,
    input  logic              lo_sel,
    input  logic              hi_sel,
    output logic [WORD-1:0]   bus_out
);

    // Combinational priority select
    always_comb begin
        bus_out = '0;
        if (lo_sel)
            bus_out = z[WORD-1:0];
        else if (hi_sel)
            bus_out = z[2*WORD-1:WORD];
    end

endmodule

// File: rtl/zhilo_capture.sv
// Result-capture stage behind the ALU: latches C into Z on Zin, drives
// Z halves onto the bus, and sequences LO-then-HI write-back for mul/div.
module zhilo_capture
    import zhilo_capture_pkg::*;
#(
    parameter int         wordSize = WORD_SIZE,
    parameter logic [4:0] OP_MUL   = OPC_MUL,
    parameter logic [4:0] OP_DIV   = OPC_DIV
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  Zin,
    input  logic [2*wordSize-1:0] C,
    input  logic [4:0]            opcode,
    input  logic                  ZLo_out,
    input  logic                  ZHi_out,
    output logic [2*wordSize-1:0] z_q,
    output logic [wordSize-1:0]   bus_out,
    output logic                  lo_we,
    output logic                  hi_we,
    output logic [wordSize-1:0]   hilo_data,
    output logic                  busy,
    output logic                  done,
    output logic                  z_drop
);

    logic [1:0]            state;
    logic [1:0]            state_n;
    logic [2*wordSize-1:0] z_n;
    logic                  accept;
    logic                  is_hilo;

    // Next-state and next-Z decode; a capture is only accepted from IDLE
    always_comb begin
        accept  = Zin && (state == ST_IDLE);
        is_hilo = (opcode == OP_MUL) || (opcode == OP_DIV);
        z_n     = accept ? C : z_q;
        state_n = state;
        case (state)
            ST_IDLE:  if (accept) state_n = is_hilo ? ST_WB_LO : ST_CAP;
            ST_CAP:   state_n = ST_IDLE;
            ST_WB_LO: state_n = ST_WB_HI;
            ST_WB_HI: state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // State, Z register and status outputs. The Moore outputs are
    // registered from state_n so they coincide with the state they
    // belong to while staying glitch-free.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= ST_IDLE;
            z_q       <= '0;
            lo_we     <= 1'b0;
            hi_we     <= 1'b0;
            hilo_data <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            z_drop    <= 1'b0;
        end else begin
            state  <= state_n;
            z_q    <= z_n;
            lo_we  <= (state_n == ST_WB_LO);
            hi_we  <= (state_n == ST_WB_HI);
            done   <= (state_n == ST_CAP) || (state_n == ST_WB_HI);
            busy   <= (state_n != ST_IDLE);
            z_drop <= Zin && (state != ST_IDLE);
            case (state_n)
                ST_WB_LO: hilo_data <= z_n[wordSize-1:0];
                ST_WB_HI: hilo_data <= z_n[2*wordSize-1:wordSize];
                default:  hilo_data <= '0;
            endcase
        end
    end

    zhilo_bus_mux #(
        .WORD(wordSize)
    ) u_bus_mux (
        .z       (z_q),
        .lo_sel  (ZLo_out),
        .hi_sel  (ZHi_out),
        .bus_out (bus_out)
    );

endmodule
